// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the fetch stage and IF/ID register:
// NOP encoding, PC step, fetch-state encoding and rs/rt positions.
package if_id_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam int          PC_STEP   = 4;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall beats load;
// anything else inserts a NOP bubble with pc+4 held.
module if_id_reg
  import if_id_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              stall,
  input  logic              load,
  input  logic [31:0]       in_instr,
  input  logic [ADDR_W-1:0] in_pc4,
  output logic [31:0]       instr_q,
  output logic [ADDR_W-1:0] pc4_q,
  output logic              valid_q
);

  logic [31:0]       instr_d;
  logic [ADDR_W-1:0] pc4_d;
  logic              valid_d;

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (stall) begin
      instr_d = instr_q;
    end else if (load) begin
      instr_d = in_instr;
      pc4_d   = in_pc4;
      valid_d = 1'b1;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch: PC, req/ack memory port, 1-entry skid
// buffer and redirect kill tracking, feeding the IF/ID register.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc_plus4,
  output logic              id_valid,
  output logic [4:0]        id_rs,
  output logic [4:0]        id_rt
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              kill_q, kill_d;
  logic [ADDR_W-1:0] kaddr_q, kaddr_d;
  logic [31:0]       skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0] skid_pc4_q, skid_pc4_d;

  logic [ADDR_W-1:0] tgt_pc;
  logic [ADDR_W-1:0] pc_inc;
  logic              accept;
  logic              hold;
  logic              unused_rdpc_lsb;

  assign tgt_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign pc_inc = pc_q + ADDR_W'(PC_STEP);
  assign hold   = (state_q == HOLD);
  assign accept = (state_q == FETCH) && imem_ack
                && !kill_q && !redirect;

  assign unused_rdpc_lsb = ^redirect_pc[1:0];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    kaddr_d      = kaddr_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
        if (redirect) pc_d = tgt_pc;
      end
      FETCH: begin
        if (imem_ack) begin
          kill_d = 1'b0;
          if (redirect) begin
            pc_d = tgt_pc;
          end else if (!kill_q) begin
            pc_d = pc_inc;
            if (stall) begin
              state_d      = HOLD;
              skid_instr_d = imem_rdata;
              skid_pc4_d   = pc_inc;
            end
          end
        end else if (redirect) begin
          // keep the in-flight address until memory acks it
          kill_d = 1'b1;
          if (!kill_q) kaddr_d = pc_q;
          pc_d = tgt_pc;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_d      = FETCH;
          pc_d         = tgt_pc;
          skid_instr_d = NOP_INSTR;
        end else if (!stall) begin
          state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      kaddr_q      <= '0;
      skid_instr_q <= NOP_INSTR;
      skid_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      kaddr_q      <= kaddr_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

  assign imem_req  = (state_q == FETCH);
  assign imem_addr = kill_q ? kaddr_q : pc_q;

  if_id_reg #(.ADDR_W(ADDR_W)) u_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect),
    .stall    (stall),
    .load     (hold || accept),
    .in_instr (hold ? skid_instr_q : imem_rdata),
    .in_pc4   (hold ? skid_pc4_q : pc_inc),
    .instr_q  (id_instr),
    .pc4_q    (id_pc_plus4),
    .valid_q  (id_valid)
  );

  assign id_rs = id_instr[RS_MSB:RS_LSB];
  assign id_rt = id_instr[RT_MSB:RT_LSB];

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed vector table, hand sequences,
// and randomized traffic against a queue-based fetch model.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;

  int n_vec = 0;
  int n_err = 0;

  localparam bit N = 1'b0;
  localparam bit Y = 1'b1;

  if_id_stage #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .id_instr    (id_instr),
    .id_pc_plus4 (id_pc_plus4),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          st;
    bit          rd;
    logic [31:0] rp;
    bit          ak;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_val;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t tbl[20];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic vec_t mk(
    input bit st, input bit rd, input logic [31:0] rp,
    input bit ak, input bit er, input logic [31:0] ea,
    input bit ev, input logic [31:0] ei,
    input logic [31:0] ep);
    vec_t v;
    v.st = st; v.rd = rd; v.rp = rp; v.ak = ak;
    v.e_req = er; v.e_addr = ea; v.e_val = ev;
    v.e_instr = ei; v.e_pc4 = ep;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input bit s, input bit r,
                     input logic [31:0] rp, input bit a);
    @(negedge clk);
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    imem_ack    = a & imem_req;
    imem_rdata  = imem_ack ? mem_data(imem_addr) : 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_id(input string nm, input bit ev,
                        input logic [31:0] ei,
                        input logic [31:0] ep);
    chk({nm, "_valid"}, 32'(id_valid), 32'(ev));
    chk({nm, "_instr"}, id_instr, ei);
    chk({nm, "_pc4"}, id_pc_plus4, ep);
    chk({nm, "_rs"}, 32'(id_rs), 32'(ei[25:21]));
    chk({nm, "_rt"}, 32'(id_rt), 32'(ei[20:16]));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    imem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // reference model state for the random phase
  bit          m_boot;
  logic [31:0] m_pc;
  bit          m_stale;
  logic [31:0] m_stale_addr;
  bit          m_val;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic [63:0] held[$];
  bit          e_req;
  logic [31:0] e_addr;
  int          wcnt;
  int          wt;

  initial begin
    do_reset();
    chk("rst_req", 32'(imem_req), 32'h0);
    chk_id("rst", N, 32'h0, 32'h0);

    tbl[0]  = mk(N,N,32'h0,N, Y,32'h0,   N,32'h0,32'h0);
    tbl[1]  = mk(N,N,32'h0,Y, Y,32'h4,   Y,mem_data(32'h0),32'h4);
    tbl[2]  = mk(N,N,32'h0,Y, Y,32'h8,   Y,mem_data(32'h4),32'h8);
    tbl[3]  = mk(N,N,32'h0,Y, Y,32'hC,   Y,mem_data(32'h8),32'hC);
    tbl[4]  = mk(N,N,32'h0,Y, Y,32'h10,  Y,mem_data(32'hC),32'h10);
    tbl[5]  = mk(Y,N,32'h0,Y, N,32'h0,   Y,mem_data(32'hC),32'h10);
    tbl[6]  = mk(Y,N,32'h0,Y, N,32'h0,   Y,mem_data(32'hC),32'h10);
    tbl[7]  = mk(Y,N,32'h0,N, N,32'h0,   Y,mem_data(32'hC),32'h10);
    tbl[8]  = mk(N,N,32'h0,N, Y,32'h14,  Y,mem_data(32'h10),32'h14);
    tbl[9]  = mk(N,N,32'h0,Y, Y,32'h18,  Y,mem_data(32'h14),32'h18);
    tbl[10] = mk(Y,Y,32'h203,Y, Y,32'h200, N,32'h0,32'h18);
    tbl[11] = mk(N,N,32'h0,Y, Y,32'h204, Y,mem_data(32'h200),32'h204);
    tbl[12] = mk(Y,N,32'h0,N, Y,32'h204, Y,mem_data(32'h200),32'h204);
    tbl[13] = mk(N,N,32'h0,N, Y,32'h204, N,32'h0,32'h204);
    tbl[14] = mk(Y,N,32'h0,Y, N,32'h0,   N,32'h0,32'h204);
    tbl[15] = mk(Y,Y,32'h302,N, Y,32'h300, N,32'h0,32'h204);
    tbl[16] = mk(N,N,32'h0,Y, Y,32'h304, Y,mem_data(32'h300),32'h304);
    tbl[17] = mk(N,Y,32'hFFFF_FFFC,Y, Y,32'hFFFF_FFFC,
                 N,32'h0,32'h304);
    tbl[18] = mk(N,N,32'h0,Y, Y,32'h0,
                 Y,mem_data(32'hFFFF_FFFC),32'h0);
    tbl[19] = mk(N,N,32'h0,Y, Y,32'h4,   Y,mem_data(32'h0),32'h4);

    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].st, tbl[i].rd, tbl[i].rp, tbl[i].ak);
      chk($sformatf("row%0d_req", i), 32'(imem_req),
          32'(tbl[i].e_req));
      if (tbl[i].e_req)
        chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk_id($sformatf("row%0d", i), tbl[i].e_val,
             tbl[i].e_instr, tbl[i].e_pc4);
    end

    // redirect while a 2-wait-state request is outstanding
    cyc(N, Y, 32'h20, Y);
    chk("kill_a_addr", imem_addr, 32'h20);
    cyc(N, N, 32'h0, N);
    chk("kill_b_addr", imem_addr, 32'h20);
    cyc(N, Y, 32'h100, N);
    chk("kill_c_req", 32'(imem_req), 32'h1);
    chk("kill_c_addr", imem_addr, 32'h20);
    chk_id("kill_c", N, 32'h0, 32'h4);
    cyc(N, N, 32'h0, Y);
    chk("kill_d_addr", imem_addr, 32'h100);
    chk_id("kill_d", N, 32'h0, 32'h4);
    cyc(N, N, 32'h0, Y);
    chk("kill_e_addr", imem_addr, 32'h104);
    chk_id("kill_e", Y, mem_data(32'h100), 32'h104);

    // reset pulsed in the middle of a pending request
    cyc(N, N, 32'h0, N);
    chk("mid_pend_req", 32'(imem_req), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(imem_req), 32'h0);
    chk_id("mid_rst", N, 32'h0, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("mid_boot_req", 32'(imem_req), 32'h0);
    cyc(N, N, 32'h0, N);
    chk("mid_f0_req", 32'(imem_req), 32'h1);
    chk("mid_f0_addr", imem_addr, 32'h0);
    cyc(N, N, 32'h0, Y);
    chk_id("mid_f1", Y, mem_data(32'h0), 32'h4);

    // randomized traffic against the model
    do_reset();
    m_boot = 1'b1;
    m_pc = 32'h0;
    m_stale = 1'b0;
    m_stale_addr = 32'h0;
    m_val = 1'b0;
    m_instr = 32'h0;
    m_pc4 = 32'h0;
    held.delete();
    wcnt = 0;
    wt = int'($urandom_range(0, 2));
    for (int c = 0; c < 2000; c++) begin
      bit st, rd, ak, fire, acc;
      logic [31:0] rp, data, tgt;
      @(negedge clk);
      e_req  = !m_boot && (held.size() == 0);
      e_addr = m_stale ? m_stale_addr : m_pc;
      chk("rnd_req", 32'(imem_req), 32'(e_req));
      if (e_req) chk("rnd_addr", imem_addr, e_addr);
      st = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 9) == 0);
      rp = $urandom;
      ak = 1'b0;
      if (imem_req) begin
        if (wcnt == wt) begin
          ak = 1'b1;
          wcnt = 0;
          wt = int'($urandom_range(0, 2));
        end else begin
          wcnt++;
        end
      end
      stall       = st;
      redirect    = rd;
      redirect_pc = rp;
      imem_ack    = ak;
      imem_rdata  = ak ? mem_data(imem_addr) : $urandom;

      tgt  = {rp[31:2], 2'b00};
      data = mem_data(e_addr);
      fire = e_req && ak;
      acc  = fire && !m_stale && !rd;
      if (rd) begin
        m_val = 1'b0;
        m_instr = 32'h0;
        held.delete();
      end else if (st) begin
        if (acc) held.push_back({data, e_addr + 32'd4});
      end else if (held.size() != 0) begin
        logic [63:0] e;
        e = held.pop_front();
        m_val = 1'b1;
        m_instr = e[63:32];
        m_pc4 = e[31:0];
      end else if (acc) begin
        m_val = 1'b1;
        m_instr = data;
        m_pc4 = e_addr + 32'd4;
      end else begin
        m_val = 1'b0;
        m_instr = 32'h0;
      end
      if (m_boot) begin
        m_boot = 1'b0;
        if (rd) m_pc = tgt;
      end else if (!e_req) begin
        if (rd) m_pc = tgt;
      end else if (fire) begin
        m_stale = 1'b0;
        if (rd) m_pc = tgt;
        else if (acc) m_pc = m_pc + 32'd4;
      end else if (rd) begin
        if (!m_stale) begin
          m_stale = 1'b1;
          m_stale_addr = m_pc;
        end
        m_pc = tgt;
      end

      @(posedge clk);
      #1;
      chk_id("rnd", m_val, m_instr, m_pc4);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline.
- Owns the PC and drives a req/ack instruction-memory port.
- Presents the fetched instruction, its PC+4 and a valid bit to the ID stage, where the register file reads rs/rt and resolves branches.
- Honours a load-use stall and a branch/jump redirect coming back from ID.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- ADDR_W, 32, PC / instruction-memory address width.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hazard unit: hold IF/ID contents and PC.
- redirect  in  1  ID: branch taken or jump this cycle.
- redirect_pc  in  ADDR_W  target of the redirect.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address; word aligned.
- imem_ack  in  1  one-cycle pulse; imem_rdata is valid in this cycle.
- imem_rdata  in  32  fetched instruction.
- id_instr  out  32  IF/ID instruction; 0 (sll $0 NOP) when invalid.
- id_pc_plus4  out  ADDR_W  IF/ID PC+4.
- id_valid  out  1  IF/ID holds a real instruction.
- id_rs  out  5  id_instr[25:21]; combinational from the register.
- id_rt  out  5  id_instr[20:16]; combinational from the register.

Behaviour:
- Reset (async, rst_n low): pc=RESET_PC, state=BOOT, imem_req=0, id_instr=0, id_pc_plus4=0, id_valid=0, skid buffer empty, kill=0.
- Reset asserted mid-request: the transaction is abandoned. Memory must tolerate a dropped req.
- States:
  - BOOT: single cycle after reset release, then FETCH.
  - FETCH: imem_req=1, imem_addr=pc.
  - HOLD: skid buffer full, imem_req=0.
- Memory rule: once imem_req rises, imem_addr stays stable until imem_ack. Ack may arrive in the same cycle as req (zero wait state).
- Throughput: with zero-wait memory and no stall, req stays high and one instruction enters IF/ID per cycle.
- Fetch latency: ack in cycle N -> id_valid=1 with that instruction after posedge N; pc=pc+4 at the same edge.
- Accepted fetch: on ack with kill=0 and no redirect, the instruction is "accepted".
  - stall=0 -> written into IF/ID.
  - stall=1 -> written into the 1-entry skid buffer; state goes to HOLD.
- HOLD: when stall drops, the buffer moves into IF/ID, the buffer empties, and state returns to FETCH (req at pc next cycle).
- IF/ID update priority, per posedge:
  1. redirect: id_valid=0, id_instr=0, skid buffer cleared, pc=redirect_pc. Wins even when stall=1.
  2. stall: hold all IF/ID fields and pc.
  3. skid buffer full: load from the buffer.
  4. accepted ack: load imem_rdata, pc+4.
  5. otherwise: bubble (id_valid=0, id_instr=0). id_pc_plus4 is held.
- Redirect while a request is outstanding (req=1, no ack yet):
  - Set kill; pc takes redirect_pc, but imem_addr keeps the old address until ack.
  - On the ack, drop the data and clear kill.
  - Next cycle, request redirect_pc.
- Redirect in the same cycle as ack: data dropped, kill not set, next request at redirect_pc.
- Redirect in HOLD: buffer discarded, state goes to FETCH at redirect_pc.
- PC arithmetic: ADDR_W-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0. redirect_pc[1:0] is ignored and forced to 0.
- ID register file writes on negedge and reads combinationally, so id_rs/id_rt must be stable from posedge, i.e. driven directly from the flop.

Decomposition:
- Shared pipeline package:
  - localparams NOP_INSTR=32'h0, PC_STEP=4.
  - Fetch-state encoding (BOOT/FETCH/HOLD).
  - RS_MSB/RS_LSB/RT_MSB/RT_LSB field positions.
- One natural sub-module: if_id_reg. It holds the IF/ID register with flush/stall/load priority and the NOP default. The PC, FSM and skid buffer stay in if_id_stage.

Test Plan:
- Reset, zero-wait memory returning addr as data, no stall -> imem_addr 0,4,8,...; id_instr tracks 1 cycle behind; id_valid=1 from the 2nd edge after BOOT; pc_plus4 = addr+4.
- stall=1 for 3 cycles while ack arrives for addr 0x10 -> id_instr/id_valid held, instruction 0x10 in buffer, imem_req=0. Stall drops -> id_instr=data(0x10), next req at 0x14.
- 2-wait-state memory; redirect to 0x100 one cycle after req at 0x20 -> imem_addr stays 0x20 until ack, data discarded, id_valid=0, next req at 0x100.
- redirect=1 and stall=1 together -> id_valid=0, id_instr=0, next fetch at redirect_pc.
- pc=0xFFFF_FFFC, ack -> next imem_addr=0x0, id_pc_plus4=0x0.
- rst_n pulsed low mid-request -> outputs immediately at reset values, req=0 during BOOT, fetch restarts at RESET_PC.
